// File: rtl/regfile_pkg.sv
// Shared constants and types for the MIPS register file and its writeback arbiter.
package regfile_pkg;

  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int NREG = 32;

  localparam logic [AW-1:0] REG_ZERO = 5'd0;

  typedef enum logic {
    WB_ALU = 1'b0,
    WB_MEM = 1'b1
  } wb_req_e;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-way round-robin grant; the pointer moves to the loser only after a contested cycle.
module rr_arb2
  import regfile_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    val0,
  input  logic    val1,
  output logic    gnt0,
  output logic    gnt1,
  output wb_req_e winner,
  output logic    contested
);

  wb_req_e ptr_q;
  wb_req_e ptr_d;

  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    winner    = WB_ALU;
    contested = val0 && val1;
    if (contested) begin
      winner = ptr_q;
      gnt0   = (ptr_q == WB_ALU);
      gnt1   = (ptr_q == WB_MEM);
    end else if (val0) begin
      winner = WB_ALU;
      gnt0   = 1'b1;
    end else if (val1) begin
      winner = WB_MEM;
      gnt1   = 1'b1;
    end
  end

  // The loser of a contested cycle gets priority next time.
  always_comb begin
    ptr_d = ptr_q;
    if (contested) begin
      ptr_d = (ptr_q == WB_ALU) ? WB_MEM : WB_ALU;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= WB_ALU;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter with output register, pending-write scoreboard
// and saturating stall counter.
module regfile_wb_arbiter #(
  parameter int AW = regfile_pkg::AW,
  parameter int DW = regfile_pkg::DW,
  parameter int CW = 16
) (
  input  logic          in_clk,
  input  logic          clr,
  input  logic          in_val0,
  input  logic          in_val1,
  input  logic [AW-1:0] in_dst0,
  input  logic [AW-1:0] in_dst1,
  input  logic [DW-1:0] in_dat0,
  input  logic [DW-1:0] in_dat1,
  output logic          out_rdy0,
  output logic          out_rdy1,
  output logic [AW-1:0] out_SC,
  output logic [DW-1:0] out_PC,
  output logic          out_RFL,
  input  logic          in_issue,
  input  logic [AW-1:0] in_issue_dst,
  input  logic [AW-1:0] in_SA,
  input  logic [AW-1:0] in_SB,
  output logic          out_hazA,
  output logic          out_hazB,
  output logic [CW-1:0] out_stalls
);

  import regfile_pkg::*;

  wb_req_e       winner;
  logic          contested;
  logic          accept;
  logic [AW-1:0] sel_dst;
  logic [DW-1:0] sel_dat;
  logic          stall_evt;

  logic          rfl_q, rfl_d;
  logic [AW-1:0] sc_q, sc_d;
  logic [DW-1:0] pc_q, pc_d;
  logic [NREG-1:0] pend_q, pend_d;
  logic [CW-1:0] stalls_q, stalls_d;

  rr_arb2 u_arb (
    .clk       (in_clk),
    .rst       (clr),
    .val0      (in_val0),
    .val1      (in_val1),
    .gnt0      (out_rdy0),
    .gnt1      (out_rdy1),
    .winner    (winner),
    .contested (contested)
  );

  assign accept    = (in_val0 && out_rdy0) || (in_val1 && out_rdy1);
  assign sel_dst   = (winner == WB_MEM) ? in_dst1 : in_dst0;
  assign sel_dat   = (winner == WB_MEM) ? in_dat1 : in_dat0;
  assign stall_evt = (in_val0 && !out_rdy0) || (in_val1 && !out_rdy1);

  // A granted write to register 0 completes the handshake but never reaches the port.
  always_comb begin
    rfl_d = 1'b0;
    sc_d  = sc_q;
    pc_d  = pc_q;
    if (accept && (sel_dst != REG_ZERO)) begin
      rfl_d = 1'b1;
      sc_d  = sel_dst;
      pc_d  = sel_dat;
    end
  end

  // Clear on commit first, then set, so a same-cycle re-issue stays pending.
  always_comb begin
    pend_d = pend_q;
    if (rfl_q) begin
      pend_d[sc_q] = 1'b0;
    end
    if (in_issue && (in_issue_dst != REG_ZERO)) begin
      pend_d[in_issue_dst] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  always_comb begin
    stalls_d = stalls_q;
    if (stall_evt && (stalls_q != {CW{1'b1}})) begin
      stalls_d = stalls_q + 1'b1;
    end
  end

  always_ff @(posedge in_clk or posedge clr) begin
    if (clr) begin
      rfl_q    <= 1'b0;
      sc_q     <= '0;
      pc_q     <= '0;
      pend_q   <= '0;
      stalls_q <= '0;
    end else begin
      rfl_q    <= rfl_d;
      sc_q     <= sc_d;
      pc_q     <= pc_d;
      pend_q   <= pend_d;
      stalls_q <= stalls_d;
    end
  end

  assign out_RFL    = rfl_q;
  assign out_SC     = sc_q;
  assign out_PC     = pc_q;
  assign out_stalls = stalls_q;
  assign out_hazA   = pend_q[in_SA];
  assign out_hazB   = pend_q[in_SB];

  // contested is consumed inside the arbiter; keep it referenced here for clarity.
  logic unused_ok;
  assign unused_ok = contested;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench: vector table, hand-written scoreboard/reset sequences,
// then randomized traffic against a behavioural model.
module tb_regfile_wb_arbiter;

  localparam int TCW = 4;
  localparam logic [TCW-1:0] SMAX = {TCW{1'b1}};

  logic        in_clk = 1'b0;
  logic        clr;
  logic        in_val0, in_val1;
  logic [4:0]  in_dst0, in_dst1;
  logic [31:0] in_dat0, in_dat1;
  logic        out_rdy0, out_rdy1;
  logic [4:0]  out_SC;
  logic [31:0] out_PC;
  logic        out_RFL;
  logic        in_issue;
  logic [4:0]  in_issue_dst;
  logic [4:0]  in_SA, in_SB;
  logic        out_hazA, out_hazB;
  logic [TCW-1:0] out_stalls;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_wb_arbiter #(.AW(5), .DW(32), .CW(TCW)) dut (
    .in_clk       (in_clk),
    .clr          (clr),
    .in_val0      (in_val0),
    .in_val1      (in_val1),
    .in_dst0      (in_dst0),
    .in_dst1      (in_dst1),
    .in_dat0      (in_dat0),
    .in_dat1      (in_dat1),
    .out_rdy0     (out_rdy0),
    .out_rdy1     (out_rdy1),
    .out_SC       (out_SC),
    .out_PC       (out_PC),
    .out_RFL      (out_RFL),
    .in_issue     (in_issue),
    .in_issue_dst (in_issue_dst),
    .in_SA        (in_SA),
    .in_SB        (in_SB),
    .out_hazA     (out_hazA),
    .out_hazB     (out_hazB),
    .out_stalls   (out_stalls)
  );

  always #5 in_clk = ~in_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_val0 = 0; in_val1 = 0; in_dst0 = 0; in_dst1 = 0;
    in_dat0 = 0; in_dat1 = 0; in_issue = 0; in_issue_dst = 0;
  endtask

  typedef struct {
    logic v0, v1;
    logic [4:0] d0, d1;
    logic [31:0] a0, a1;
    logic e_r0, e_r1, e_rfl;
    logic [4:0] e_sc;
    logic [31:0] e_pc;
    logic [TCW-1:0] e_st;
  } vec_t;

  vec_t vecs[12];

  // Behavioural reference state for the random phase
  int          m_ptr;
  bit [31:0]   m_pend;
  bit          m_rfl;
  bit [4:0]    m_sc;
  bit [31:0]   m_pc;
  int          m_st;

  initial begin
    //        v0 v1 d0 d1  a0            a1            r0 r1 rfl sc  pc            st
    vecs[0]  = '{1, 0, 5, 0,  32'hDEADBEEF, 32'h0,        1, 0, 1,  5,  32'hDEADBEEF, 0};
    vecs[1]  = '{0, 0, 0, 0,  32'h0,        32'h0,        0, 0, 0,  5,  32'hDEADBEEF, 0};
    vecs[2]  = '{1, 1, 3, 4,  32'hA3,       32'hB4,       1, 0, 1,  3,  32'hA3,       1};
    vecs[3]  = '{1, 1, 3, 4,  32'hA3,       32'hB4,       0, 1, 1,  4,  32'hB4,       2};
    vecs[4]  = '{1, 1, 3, 4,  32'hA3,       32'hB4,       1, 0, 1,  3,  32'hA3,       3};
    vecs[5]  = '{1, 1, 3, 4,  32'hA3,       32'hB4,       0, 1, 1,  4,  32'hB4,       4};
    vecs[6]  = '{0, 1, 0, 0,  32'h0,        32'h1234,     0, 1, 0,  4,  32'hB4,       4};
    vecs[7]  = '{0, 1, 0, 9,  32'h0,        32'h99,       0, 1, 1,  9,  32'h99,       4};
    vecs[8]  = '{1, 1, 10, 11, 32'hAA,      32'hBB,       1, 0, 1,  10, 32'hAA,       5};
    vecs[9]  = '{1, 0, 6, 0,  32'h66,       32'h0,        1, 0, 1,  6,  32'h66,       5};
    vecs[10] = '{1, 1, 1, 2,  32'h11,       32'h22,       0, 1, 1,  2,  32'h22,       6};
    vecs[11] = '{1, 1, 13, 14, 32'h0D,      32'h0E,       1, 0, 1,  13, 32'h0D,       7};

    clr = 1; idle_inputs(); in_SA = 0; in_SB = 0;
    #22;
    @(negedge in_clk); clr = 0;
    #1;
    check("reset_rfl", out_RFL, 0);
    check("reset_sc", out_SC, 0);
    check("reset_pc", out_PC, 0);
    check("reset_stalls", out_stalls, 0);
    check("reset_rdy0", out_rdy0, 0);
    check("reset_rdy1", out_rdy1, 0);
    for (int r = 0; r < 32; r += 5) begin
      in_SA = 5'(r); in_SB = 5'(31 - r); #1;
      check("reset_hazA", out_hazA, 0);
      check("reset_hazB", out_hazB, 0);
    end
    tick();

    // Vector table: combinational grant, then registered outputs after the edge
    for (int i = 0; i < 12; i++) begin
      in_val0 = vecs[i].v0; in_val1 = vecs[i].v1;
      in_dst0 = vecs[i].d0; in_dst1 = vecs[i].d1;
      in_dat0 = vecs[i].a0; in_dat1 = vecs[i].a1;
      #1;
      check($sformatf("vec%0d_rdy0", i), out_rdy0, vecs[i].e_r0);
      check($sformatf("vec%0d_rdy1", i), out_rdy1, vecs[i].e_r1);
      tick();
      check($sformatf("vec%0d_rfl", i), out_RFL, vecs[i].e_rfl);
      check($sformatf("vec%0d_sc", i), out_SC, vecs[i].e_sc);
      check($sformatf("vec%0d_pc", i), out_PC, vecs[i].e_pc);
      check($sformatf("vec%0d_stalls", i), out_stalls, vecs[i].e_st);
      $display("vec %0d: rdy=%b%b rfl=%b sc=%0d pc=%0h stalls=%0d",
               i, vecs[i].e_r0, vecs[i].e_r1, out_RFL, out_SC, out_PC, out_stalls);
    end

    // Scoreboard: set, hold through commit cycle, clear after commit
    idle_inputs();
    in_issue = 1; in_issue_dst = 7; in_SA = 7; in_SB = 3;
    #1; check("haz_before_set", out_hazA, 0);
    tick(); in_issue = 0;
    check("haz_set", out_hazA, 1);
    check("haz_other", out_hazB, 0);
    in_val0 = 1; in_dst0 = 7; in_dat0 = 32'h77;
    tick(); in_val0 = 0;
    check("haz_hold", out_hazA, 1);
    tick();
    check("haz_clear", out_hazA, 0);
    $display("scoreboard set/clear sequence done");

    // Re-issue on the commit edge keeps the register pending
    in_issue = 1; in_issue_dst = 7; tick(); in_issue = 0;
    in_val0 = 1; in_dst0 = 7; in_dat0 = 32'h78;
    tick(); in_val0 = 0;
    in_issue = 1; in_issue_dst = 7;
    tick(); in_issue = 0;
    check("haz_race", out_hazA, 1);
    tick();
    check("haz_race_hold", out_hazA, 1);
    in_issue = 1; in_issue_dst = 0; in_SB = 0;
    tick(); in_issue = 0;
    check("haz_reg0", out_hazB, 0);
    $display("scoreboard re-issue sequence done");

    // Mid-write asynchronous reset
    in_val0 = 1; in_dst0 = 12; in_dat0 = 32'hC0C0;
    tick(); in_val0 = 0;
    check("pre_reset_rfl", out_RFL, 1);
    #2 clr = 1;
    #1;
    check("async_rfl", out_RFL, 0);
    check("async_sc", out_SC, 0);
    check("async_pc", out_PC, 0);
    check("async_stalls", out_stalls, 0);
    check("async_pend", out_hazA, 0);
    @(negedge in_clk); clr = 0;
    tick();
    in_val0 = 1; in_val1 = 1; in_dst0 = 1; in_dst1 = 2;
    #1;
    check("ptr_reset_rdy0", out_rdy0, 1);
    check("ptr_reset_rdy1", out_rdy1, 0);
    idle_inputs();
    $display("mid-write reset sequence done");

    // Randomized traffic against the behavioural model
    clr = 1; #3; clr = 0;
    m_ptr = 0; m_pend = 0; m_rfl = 0; m_sc = 0; m_pc = 0; m_st = 0;
    tick();
    for (int c = 0; c < 400; c++) begin
      int win;
      logic [4:0] wd;
      logic [31:0] wa;
      in_val0 = ($urandom_range(0, 3) != 0);
      in_val1 = ($urandom_range(0, 2) == 0);
      in_dst0 = 5'($urandom_range(0, 7));
      in_dst1 = 5'($urandom_range(0, 7));
      in_dat0 = $urandom; in_dat1 = $urandom;
      in_issue = ($urandom_range(0, 1) == 1);
      in_issue_dst = 5'($urandom_range(0, 7));
      in_SA = 5'($urandom_range(0, 7));
      in_SB = 5'($urandom_range(0, 7));
      #1;
      win = -1;
      if (in_val0 && in_val1) win = m_ptr;
      else if (in_val0) win = 0;
      else if (in_val1) win = 1;
      check("rand_rdy0", out_rdy0, (win == 0));
      check("rand_rdy1", out_rdy1, (win == 1));
      check("rand_hazA", out_hazA, m_pend[in_SA]);
      check("rand_hazB", out_hazB, m_pend[in_SB]);

      if (in_val0 && in_val1) begin
        m_ptr = 1 - m_ptr;
        if (m_st < int'(SMAX)) m_st++;
      end
      if (m_rfl) m_pend[m_sc] = 1'b0;
      if (in_issue && in_issue_dst != 0) m_pend[in_issue_dst] = 1'b1;
      if (win >= 0) begin
        wd = (win == 1) ? in_dst1 : in_dst0;
        wa = (win == 1) ? in_dat1 : in_dat0;
        if (wd != 0) begin
          m_rfl = 1; m_sc = wd; m_pc = wa;
        end else begin
          m_rfl = 0;
        end
      end else begin
        m_rfl = 0;
      end

      tick();
      check("rand_rfl", out_RFL, m_rfl);
      check("rand_sc", out_SC, m_sc);
      check("rand_pc", out_PC, m_pc);
      check("rand_stalls", out_stalls, m_st);
      if (c % 50 == 0)
        $display("rand %0d: win=%0d rfl=%b sc=%0d stalls=%0d", c, win, out_RFL, out_SC, out_stalls);
    end
    idle_inputs();
    check("stalls_saturated", out_stalls, SMAX);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port arbiter and pending-write scoreboard for the 32×32 MIPS register file. Two writeback sources, the ALU result path (requester 0) and the load-data path (requester 1), share the register file's single write port (SC/PC/RFL) through a round-robin valid/ready handshake. The block tracks which destination registers have an issued but uncommitted write, and flags read-after-write hazards for the two read selects SA/SB. It sits between the pipeline writeback stage and the register file.

## Interface
Parameters:
- AW, 5, register address width
- DW, 32, data width
- CW, 16, stall-counter width

Ports:
- in_clk  input  1  clock; all state updates on rising edge
- clr  input  1  asynchronous, active-high reset
- in_val0 / in_val1  input  1  requester 0/1 has a write pending
- in_dst0 / in_dst1  input  AW  requester destination register
- in_dat0 / in_dat1  input  DW  requester write data
- out_rdy0 / out_rdy1  output  1  grant; handshake completes on an edge where val&&rdy
- out_SC  output  AW  register-file write select
- out_PC  output  DW  register-file write data
- out_RFL  output  1  register-file load enable
- in_issue  input  1  decode issued an instruction that will write in_issue_dst
- in_issue_dst  input  AW  destination of the issued instruction
- in_SA / in_SB  input  AW  register-file read selects
- out_hazA / out_hazB  output  1  the selected register has a pending write
- out_stalls  output  CW  saturating count of cycles in which some valid requester was not granted

## Operation
- Grant is combinational from in_val*, the priority pointer `ptr`, and nothing else.
  - Only one requester valid: that requester wins.
  - Both valid: requester `ptr` wins.
  - Neither valid: no grant.
  - out_rdyN = 1 only for the winner; at most one ready per cycle.
- `ptr` flips to the loser only after a contested grant (both valid). An uncontested grant leaves `ptr` unchanged.
- On an accept edge:
  - out_SC ← dst, out_PC ← dat.
  - out_RFL ← 1, unless dst = 0. A write to register 0 completes the handshake, but out_RFL ← 0 and out_SC/out_PC hold.
- With no accept, out_RFL ← 0 and out_SC/out_PC hold.
- Scoreboard: 32-bit `pend` vector.
  - Set: in_issue && in_issue_dst ≠ 0 sets pend[in_issue_dst].
  - Clear: out_RFL clears pend[out_SC], i.e. on the edge the register file commits.
  - Set and clear on the same register in the same cycle: set wins, because a newer write is outstanding.
  - pend[0] is constant 0.
- out_hazA = pend[in_SA], out_hazB = pend[in_SB]. Both are combinational, with no forwarding.
- out_stalls increments on each edge where in_val0||in_val1 and the corresponding ready is 0 for at least one valid requester. It saturates at 2^CW−1 and never wraps.
- Reset values (asynchronous on clr):
  - out_RFL=0, out_SC=0, out_PC=0, ptr=0, pend=0, out_stalls=0.
  - out_rdy*/out_haz* follow the reset state combinationally.
- Reset mid-operation: any write held in the output register is discarded (out_RFL drops immediately), and all pending bits are lost. Requesters re-present after clr deasserts.

## Timing
- Write latency: accept at edge k → out_RFL high during cycle k+1 → register file writes at edge k+1 → pend cleared at edge k+1.
- Throughput is one write per cycle. Back-to-back accepts keep out_RFL high continuously.
- A requester holds val/dst/dat stable until accepted. Dropping val before accept is legal and loses nothing.
- Hazard reflects a set at edge k from cycle k+1 onward. A register written at edge k+1 reads hazard-free from cycle k+2.
- Contested traffic alternates strictly: 0,1,0,1… starting with 0 after reset.

## Structure
- Shared package regfile_pkg holds:
  - AW, DW, and NREG=32 constants.
  - REG_ZERO=5'd0.
  - A requester-index enum: WB_ALU=0, WB_MEM=1.
  The register-file top and this block both import it.
- One sub-module, rr_arb2: a two-way round-robin grant with its pointer flop.
- Scoreboard, output register and counter live in the top.

## Test plan
1. Reset then idle: after clr, all outputs 0, out_hazA/B=0 for all SA/SB, out_stalls=0.
2. Single ALU write: val0=1, dst0=5, dat0=32'hDEADBEEF for one cycle.
   - Next cycle: out_RFL=1, out_SC=5, out_PC=32'hDEADBEEF.
   - The following cycle: out_RFL=0.
3. Contention: val0 and val1 held with dst0=3, dst1=4 for 4 cycles.
   - Grants go 0,1,0,1.
   - out_SC sequence is 3,4,3,4.
   - out_stalls=4 after the 4 edges.
4. Register 0 write: dst1=0, val1=1.
   - out_rdy1=1 and the handshake completes.
   - out_RFL stays 0, and out_SC/out_PC keep their previous values.
5. Scoreboard: issue dst=7, with in_SA=7.
   - out_hazA=1 from the next cycle onward.
   - After a write to 7 is accepted, out_hazA=0 two cycles after the accept edge.
   - A re-issue of 7 on the commit edge keeps out_hazA=1.
6. Mid-write reset: assert clr asynchronously while out_RFL=1 → out_RFL drops immediately, pend clears, ptr=0.
